uart_loopback_sequencer: RTL and testbench
==========================================

// Module: uart_loopback_sequencer
// PURPOSE
//   Self-test controller for the board UART pins. On a start pulse it drives a
//   known byte pattern out of fpag_uart_tx, one byte at a time, 8N1.
//   It receives each byte back on fpag_uart_rx (external or FPGA loopback) and
//   compares it with the expected value. It counts mismatch, framing and timeout
//   errors and reports pass/fail. It contains its own bit-timed TX serializer and
//   RX deserializer, and sits directly on the UART pins in place of a plain wire.
// PARAMETERS
//   CLKS_PER_BIT  434  clk cycles per UART bit (50 MHz / 115200); must be >= 4
//   NUM_BYTES     256  bytes sent per test run; must be >= 1 and < 2**IDX_W
//   IDX_W         16   width of byte_idx and of the internal byte counter
//   TIMEOUT_BITS  20   bit-times to wait for the echo after TX stop bit ends
// PORTS
//   clk           in   1      system clock, all logic rising-edge
//   rst_n         in   1      asynchronous active-low reset
//   start         in   1      1-cycle pulse: begin a test run; ignored while busy=1
//   fpag_uart_rx  in   1      UART receive pin, asynchronous, idle high
//   fpag_uart_tx  out  1      UART transmit pin, idle high
//   busy          out  1      run in progress
//   done          out  1      1-cycle pulse when a run completes
//   pass          out  1      1 = last completed run had err_count==0; held until next start
//   err_count     out  8      errors in current/last run, saturates at 255
//   byte_idx      out  IDX_W  index of byte currently under test
// BEHAVIOUR
//   Reset values (async, immediate)
//   - fpag_uart_tx=1, busy=0, done=0, pass=0, err_count=0, byte_idx=0.
//   - State=IDLE; all bit/baud/timeout counters=0.
//   Expected pattern
//   - byte n = n[7:0] ^ 8'hA5.
//   - Frame: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
//   - Each bit lasts exactly CLKS_PER_BIT clks.
//   RX deserializer
//   - 2-FF synchronizer on fpag_uart_rx.
//   - Falling edge while idle starts a frame. The start bit is re-sampled at
//     CLKS_PER_BIT/2; if it is 1, the frame is a glitch: discard, no error.
//   - Data and stop bits are sampled at mid-bit.
//   - At the stop sample the deserializer raises rx_valid (internal, 1 cycle),
//     together with rx_byte and rx_ferr = (stop==0).
//   - The RX is always running; rx_valid is ignored outside SEND/WAIT_RX.
//   State machine
//   - IDLE: on start -> clear err_count, byte_idx=0, pass=0, busy=1 -> SEND.
//   - SEND: serialize pattern byte. Latch rx_valid/rx_byte/rx_ferr into a
//     holding register if they arrive during SEND. At end of stop bit:
//     held result present -> CHECK, else -> WAIT_RX.
//   - WAIT_RX: count clks. rx_valid -> latch -> CHECK.
//     Count reaches TIMEOUT_BITS*CLKS_PER_BIT -> flag timeout -> CHECK.
//   - CHECK (1 cycle): error if timeout | rx_ferr | rx_byte != expected.
//     err_count += 1, saturating at 255. Clear the holding register.
//     If byte_idx==NUM_BYTES-1 -> DONE; else byte_idx++ -> SEND.
//   - DONE (1 cycle): done=1, busy=0, pass=(err_count==0) -> IDLE.
//   Timing and boundary rules
//   - First start-bit edge on fpag_uart_tx occurs 1 clk after the start pulse.
//   - Consecutive frames are separated by the CHECK cycle plus 1 clk: TX returns
//     to idle high for at least 2 clks between stop bit and next start bit.
//   - A second rx_valid within one byte slot keeps the first result only.
//     It counts no extra error.
//   - rx_valid and timeout in the same cycle: treat as received (no timeout error).
//   - start coincident with DONE is ignored; start is accepted only in IDLE.
//   - rst_n low mid-frame: TX drives 1 immediately, the run is abandoned,
//     and no done pulse is produced.
// TESTING
//   1 CLKS_PER_BIT=8, NUM_BYTES=4, tx looped to rx, start -> frames A5,A4,A7,A6
//     on tx; done pulse; pass=1, err_count=0.
//   2 rx tied high, NUM_BYTES=4 -> each byte times out after 160 clks;
//     err_count=4, pass=0.
//   3 Loopback with bench flipping data bit 0 of byte 2 (A7->A6 seen)
//     -> err_count=1, pass=0.
//   4 Bench forces stop bit 0 on byte 0 echo -> framing error, err_count=1;
//     remaining bytes clean.
//   5 start pulsed while busy -> ignored, run unaffected. rst_n low mid-byte 1
//     -> tx=1, busy=0 at once. A new start afterwards gives a clean run, pass=1.
//   6 NUM_BYTES=300, rx tied high -> err_count saturates at 255; done asserted
//     after byte_idx 299; pass=0.

Source files
------------

// File: rtl/uart_loopback_sequencer.sv
// UART pin self-test: sends idx^A5 frames 8N1, checks each echo,
// counts mismatch/framing/timeout errors and reports pass/fail.
module uart_loopback_sequencer #(
  parameter int CLKS_PER_BIT = 434,
  parameter int NUM_BYTES    = 256,
  parameter int IDX_W        = 16,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             fpag_uart_rx,
  output logic             fpag_uart_tx,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       err_count,
  output logic [IDX_W-1:0] byte_idx
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int TO_CLKS = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW = $clog2(TO_CLKS + 1);

  localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] C_ONE = CW'(1);
  localparam logic [TW-1:0] TO_END = TW'(TO_CLKS - 1);
  localparam logic [TW-1:0] T_ONE = TW'(1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_BYTES - 1);
  localparam logic [IDX_W-1:0] I_ONE = IDX_W'(1);

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_START = 2'd1;
  localparam logic [1:0] R_DATA  = 2'd2;
  localparam logic [1:0] R_STOP  = 2'd3;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SEND  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic          rx_m, rx_s, rx_d;
  logic [1:0]    rx_st;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_sh;
  logic [7:0]    rx_byte;
  logic          rx_valid;
  logic          rx_ferr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= fpag_uart_rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  // Edge-triggered start so a line held low never re-arms the receiver
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_st    <= R_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      unique case (rx_st)
        R_IDLE: begin
          rx_cnt <= '0;
          if (rx_d && !rx_s) rx_st <= R_START;
        end
        R_START: begin
          if (rx_cnt == HALF) begin
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_st  <= rx_s ? R_IDLE : R_DATA;
          end else begin
            rx_cnt <= rx_cnt + C_ONE;
          end
        end
        R_DATA: begin
          if (rx_cnt == BIT_END) begin
            rx_cnt <= '0;
            rx_sh  <= {rx_s, rx_sh[7:1]};
            rx_bit <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_st <= R_STOP;
          end else begin
            rx_cnt <= rx_cnt + C_ONE;
          end
        end
        R_STOP: begin
          if (rx_cnt == BIT_END) begin
            rx_cnt   <= '0;
            rx_valid <= 1'b1;
            rx_byte  <= rx_sh;
            rx_ferr  <= !rx_s;
            rx_st    <= R_IDLE;
          end else begin
            rx_cnt <= rx_cnt + C_ONE;
          end
        end
        default: rx_st <= R_IDLE;
      endcase
    end
  end

  logic [2:0]       state;
  logic             tx_q;
  logic             tx_lead;
  logic [3:0]       tx_bit;
  logic [CW-1:0]    baud;
  logic [TW-1:0]    wcnt;
  logic             hold_v;
  logic [7:0]       hold_byte;
  logic             hold_ferr;
  logic             to_flag;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [7:0]       err_q;
  logic [IDX_W-1:0] idx_q;

  logic [7:0] exp_byte;
  logic [3:0] tx_nxt;
  logic       tx_nval;
  logic       byte_err;
  logic [7:0] err_nxt;

  always_comb begin
    exp_byte = 8'(idx_q) ^ 8'hA5;
    tx_nxt   = tx_bit + 4'd1;
    tx_nval  = (tx_nxt == 4'd9) ? 1'b1 : exp_byte[tx_bit[2:0]];
    byte_err = to_flag | hold_ferr | (hold_byte != exp_byte);
    err_nxt  = err_q;
    if (byte_err && err_q != 8'hFF) err_nxt = err_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      tx_q      <= 1'b1;
      tx_lead   <= 1'b0;
      tx_bit    <= '0;
      baud      <= '0;
      wcnt      <= '0;
      hold_v    <= 1'b0;
      hold_byte <= '0;
      hold_ferr <= 1'b0;
      to_flag   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_q     <= '0;
      idx_q     <= '0;
    end else begin
      done_q <= 1'b0;
      // First echo in a byte slot wins; later ones are dropped
      if ((state == S_SEND || state == S_WAIT)
          && rx_valid && !hold_v) begin
        hold_v    <= 1'b1;
        hold_byte <= rx_byte;
        hold_ferr <= rx_ferr;
      end
      unique case (state)
        S_IDLE: begin
          if (start) begin
            err_q   <= '0;
            idx_q   <= '0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b1;
            tx_lead <= 1'b1;
            tx_bit  <= '0;
            baud    <= '0;
            state   <= S_SEND;
          end
        end
        S_SEND: begin
          if (tx_lead) begin
            tx_lead <= 1'b0;
            tx_q    <= 1'b0;
          end else if (baud == BIT_END) begin
            baud <= '0;
            if (tx_bit == 4'd9) begin
              wcnt  <= '0;
              state <= (hold_v || rx_valid) ? S_CHECK : S_WAIT;
            end else begin
              tx_bit <= tx_nxt;
              tx_q   <= tx_nval;
            end
          end else begin
            baud <= baud + C_ONE;
          end
        end
        S_WAIT: begin
          if (rx_valid) begin
            state <= S_CHECK;
          end else if (wcnt == TO_END) begin
            to_flag <= 1'b1;
            state   <= S_CHECK;
          end else begin
            wcnt <= wcnt + T_ONE;
          end
        end
        S_CHECK: begin
          err_q     <= err_nxt;
          hold_v    <= 1'b0;
          hold_byte <= '0;
          hold_ferr <= 1'b0;
          to_flag   <= 1'b0;
          if (idx_q == LAST) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            pass_q <= (err_nxt == 8'd0);
            state  <= S_DONE;
          end else begin
            idx_q   <= idx_q + I_ONE;
            tx_lead <= 1'b1;
            tx_bit  <= '0;
            baud    <= '0;
            state   <= S_SEND;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign fpag_uart_tx = tx_q;
  assign busy = busy_q;
  assign done = done_q;
  assign pass = pass_q;
  assign err_count = err_q;
  assign byte_idx = idx_q;

endmodule

// File: tb/tb_uart_loopback_sequencer.sv
// Bench for uart_loopback_sequencer: loopback, timeout, corruption,
// reset abort and saturation runs checked through result queues.
`timescale 1ns/1ps
module tb_uart_loopback_sequencer;

  localparam int CPB = 8;

  typedef struct packed {
    logic        p;
    logic [7:0]  e;
    logic [15:0] i;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rst_big_n, start, start_big;
  logic rx, tx, busy, done, pass;
  logic [7:0] err;
  logic [15:0] idx;
  logic tx_b, busy_b, done_b, pass_b;
  logic [7:0] err_b;
  logic [15:0] idx_b;

  logic rx_tied, corrupt, txmon_en;
  int frame, corrupt_frame, corrupt_bit;
  int total = 0, bad = 0;
  int n_done = 0, n_done_b = 0;

  res_t q_small[$];
  res_t q_big[$];
  logic [7:0] q_txb[$];

  assign rx = rx_tied ? 1'b1 : (tx ^ corrupt);

  uart_loopback_sequencer #(
    .CLKS_PER_BIT(CPB), .NUM_BYTES(4),
    .IDX_W(16), .TIMEOUT_BITS(20)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .fpag_uart_rx(rx), .fpag_uart_tx(tx),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err), .byte_idx(idx)
  );

  uart_loopback_sequencer #(
    .CLKS_PER_BIT(CPB), .NUM_BYTES(300),
    .IDX_W(16), .TIMEOUT_BITS(4)
  ) u_big (
    .clk(clk), .rst_n(rst_big_n), .start(start_big),
    .fpag_uart_rx(1'b1), .fpag_uart_tx(tx_b),
    .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_b), .byte_idx(idx_b)
  );

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic res_t mk(logic p, int e, int i);
    res_t r;
    r.p = p;
    r.e = 8'(e);
    r.i = 16'(i);
    return r;
  endfunction

  always @(negedge clk) begin : mon_small
    res_t e;
    if (done) begin
      if (q_small.size() == 0) begin
        chk("small_unexpected_done", 1, 0);
      end else begin
        e = q_small.pop_front();
        chk("small_pass", pass, e.p);
        chk("small_err", err, e.e);
        chk("small_idx", idx, e.i);
        chk("small_busy_at_done", busy, 0);
      end
      n_done++;
    end
  end

  always @(negedge clk) begin : mon_big
    res_t e;
    if (done_b) begin
      if (q_big.size() == 0) begin
        chk("big_unexpected_done", 1, 0);
      end else begin
        e = q_big.pop_front();
        chk("big_pass", pass_b, e.p);
        chk("big_err", err_b, e.e);
        chk("big_idx", idx_b, e.i);
      end
      n_done_b++;
    end
  end

  initial begin : txmon
    logic [7:0] b;
    logic [7:0] e;
    forever begin
      @(negedge tx);
      if (txmon_en) begin
        repeat (CPB / 2) @(posedge clk);
        #1 chk("tx_start_bit", tx, 0);
        for (int k = 0; k < 8; k++) begin
          repeat (CPB) @(posedge clk);
          #1 b[k] = tx;
        end
        repeat (CPB) @(posedge clk);
        #1 chk("tx_stop_bit", tx, 1);
        if (q_txb.size() == 0) begin
          chk("tx_unexpected_frame", 1, 0);
        end else begin
          e = q_txb.pop_front();
          chk("tx_byte", b, e);
        end
      end
    end
  end

  initial begin : echo
    int el;
    corrupt = 1'b0;
    forever begin
      @(negedge tx);
      el = 0;
      if (frame == corrupt_frame) begin
        repeat (CPB * (1 + corrupt_bit)) @(posedge clk);
        corrupt = 1'b1;
        repeat (CPB) @(posedge clk);
        corrupt = 1'b0;
        el = (2 + corrupt_bit) * CPB;
      end
      if (el < 9 * CPB + 2) repeat (9 * CPB + 2 - el) @(posedge clk);
      frame++;
    end
  end

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_small(int target, int budget);
    for (int i = 0; i < budget && n_done < target; i++)
      @(posedge clk);
    chk("small_run_timeout", int'(n_done >= target), 1);
  endtask

  initial begin
    rst_n = 1'b1;
    rst_big_n = 1'b1;
    start = 1'b0;
    start_big = 1'b0;
    rx_tied = 1'b0;
    txmon_en = 1'b0;
    frame = 0;
    corrupt_frame = -1;
    corrupt_bit = 0;
    #2;
    rst_n = 1'b0;
    rst_big_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err, 0);
    chk("rst_idx", idx, 0);
    chk("rst_big_tx", tx_b, 1);
    @(negedge clk);
    rst_n = 1'b1;
    rst_big_n = 1'b1;

    // saturation run proceeds in the background
    q_big.push_back(mk(1'b0, 255, 299));
    @(posedge clk);
    #1 start_big = 1'b1;
    @(posedge clk);
    #1 start_big = 1'b0;

    // clean loopback, frames checked on the pin
    txmon_en = 1'b1;
    q_txb.push_back(8'hA5);
    q_txb.push_back(8'hA4);
    q_txb.push_back(8'hA7);
    q_txb.push_back(8'hA6);
    q_small.push_back(mk(1'b1, 0, 3));
    pulse_start();
    chk("t1_busy", busy, 1);
    wait_small(1, 3000);
    txmon_en = 1'b0;

    // no echo: every byte times out
    rx_tied = 1'b1;
    q_small.push_back(mk(1'b0, 4, 3));
    pulse_start();
    chk("t2_pass_cleared", pass, 0);
    chk("t2_busy", busy, 1);
    wait_small(2, 3000);
    rx_tied = 1'b0;

    // data bit 0 of byte 2 flipped on the echo
    frame = 0;
    corrupt_frame = 2;
    corrupt_bit = 0;
    q_small.push_back(mk(1'b0, 1, 3));
    pulse_start();
    chk("t3_err_cleared", err, 0);
    chk("t3_idx_cleared", idx, 0);
    wait_small(3, 3000);
    corrupt_frame = -1;

    // stop bit of byte 0 forced low
    frame = 0;
    corrupt_frame = 0;
    corrupt_bit = 8;
    q_small.push_back(mk(1'b0, 1, 3));
    pulse_start();
    wait_small(4, 3000);
    corrupt_frame = -1;

    // start while busy is ignored
    q_small.push_back(mk(1'b1, 0, 3));
    pulse_start();
    repeat (30) @(posedge clk);
    pulse_start();
    chk("t5_busy_after_restart", busy, 1);
    chk("t5_idx_after_restart", idx, 0);
    wait_small(5, 3000);

    // reset in the middle of byte 1 abandons the run
    pulse_start();
    repeat (95) @(posedge clk);
    #1;
    chk("t5_idx_mid", idx, 1);
    chk("t5_tx_low_mid", tx, 0);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_tx", tx, 1);
    chk("t5_rst_busy", busy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(posedge clk);
    chk("t5_no_done_after_rst", n_done, 5);
    q_small.push_back(mk(1'b1, 0, 3));
    pulse_start();
    wait_small(6, 3000);

    for (int i = 0; i < 60000 && n_done_b < 1; i++)
      @(posedge clk);
    chk("big_run_timeout", int'(n_done_b >= 1), 1);

    repeat (5) @(posedge clk);
    chk("q_small_left", q_small.size(), 0);
    chk("q_big_left", q_big.size(), 0);
    chk("q_txb_left", q_txb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
